// File: rtl/mor_gradient_stream.sv
// Streaming 3x3 morphological-gradient engine: two line buffers build the window,
// one registered result per interior pixel. Optional out_dir port under MOR_GRAD_DIR_EN.
module mor_gradient_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  input  logic [1:0]       mode,
  input  logic [PIX_W+2:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sof,
  output logic             out_eof
`ifdef MOR_GRAD_DIR_EN
  ,
  output logic [1:0]       out_dir
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DW = PIX_W + 1;
  localparam int SW = PIX_W + 3;
  localparam logic [CW-1:0] LP_COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LP_ROW_LAST = RW'(IMG_H - 1);
  localparam logic [SW-1:0] LP_SAT_MAX  = SW'((64'd1 << OUT_W) - 64'd1);

  function automatic logic [DW-1:0] f_absdiff(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b);
    return (a > b) ? DW'(a - b) : DW'(b - a);
  endfunction

  function automatic logic [OUT_W-1:0] f_sat(input logic [SW-1:0] v);
    if (v > LP_SAT_MAX) return '1;
    return v[OUT_W-1:0];
  endfunction

  logic [CW-1:0]    r_col, w_col;
  logic [RW-1:0]    r_row, w_row;
  logic [1:0]       r_mode;
  logic [SW-1:0]    r_thresh;
  logic [PIX_W-1:0] r_lb1 [IMG_W];
  logic [PIX_W-1:0] r_lb2 [IMG_W];
  logic [PIX_W-1:0] r_a1, r_a2, r_b1, r_b2, r_c1, r_c2;
  logic [PIX_W-1:0] w_lb1_rd, w_lb2_rd;
  logic [PIX_W-1:0] w_z1, w_z2, w_z3, w_z4, w_z5, w_z6, w_z7, w_z8, w_z9;
  logic [DW-1:0]    w_d1, w_d2, w_d3, w_d4, w_max;
  logic [SW-1:0]    w_sum;
  logic [1:0]       w_dir;
  logic [OUT_W-1:0] w_res;
  logic             w_acc, w_gen, w_sof, w_eof;
  logic             r_out_valid, r_out_sof, r_out_eof;
  logic [OUT_W-1:0] r_out_data;
  logic [1:0]       r_out_dir;

  assign in_ready = !r_out_valid || out_ready;
  assign w_acc    = in_valid && in_ready;
  // An accepted in_sof pins this pixel to (0,0) regardless of the running count
  assign w_col    = in_sof ? '0 : r_col;
  assign w_row    = in_sof ? '0 : r_row;
  assign w_gen    = w_acc && (w_row >= RW'(2)) && (w_col >= CW'(2));
  assign w_sof    = (w_row == RW'(2)) && (w_col == CW'(2));
  assign w_eof    = (w_row == LP_ROW_LAST) && (w_col == LP_COL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_mode   <= '0;
      r_thresh <= '0;
    end else if (w_acc) begin
      if (w_col == LP_COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == LP_ROW_LAST) ? '0 : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
      if (in_sof) begin
        r_mode   <= mode;
        r_thresh <= thresh;
      end
    end
  end

  assign w_lb1_rd = r_lb1[w_col];
  assign w_lb2_rd = r_lb2[w_col];

  // Line buffers and column taps carry pure data and are never reset
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb1[w_col] <= in_pixel;
      r_lb2[w_col] <= w_lb1_rd;
      r_a1 <= in_pixel;
      r_a2 <= r_a1;
      r_b1 <= w_lb1_rd;
      r_b2 <= r_b1;
      r_c1 <= w_lb2_rd;
      r_c2 <= r_c1;
    end
  end

  assign w_z1 = r_c2;
  assign w_z2 = r_c1;
  assign w_z3 = w_lb2_rd;
  assign w_z4 = r_b2;
  assign w_z5 = r_b1;
  assign w_z6 = w_lb1_rd;
  assign w_z7 = r_a2;
  assign w_z8 = r_a1;
  assign w_z9 = in_pixel;

  assign w_d1  = f_absdiff(w_z5, w_z2) + f_absdiff(w_z8, w_z5);
  assign w_d2  = f_absdiff(w_z5, w_z4) + f_absdiff(w_z6, w_z5);
  assign w_d3  = f_absdiff(w_z5, w_z1) + f_absdiff(w_z9, w_z5);
  assign w_d4  = f_absdiff(w_z5, w_z3) + f_absdiff(w_z7, w_z5);
  assign w_sum = SW'(w_d1) + SW'(w_d2) + SW'(w_d3) + SW'(w_d4);

  // Strict compares keep the lowest index on ties
  always_comb begin
    w_max = w_d1;
    w_dir = 2'd0;
    if (w_d2 > w_max) begin w_max = w_d2; w_dir = 2'd1; end
    if (w_d3 > w_max) begin w_max = w_d3; w_dir = 2'd2; end
    if (w_d4 > w_max) begin w_max = w_d4; w_dir = 2'd3; end
  end

  always_comb begin
    w_res = f_sat(w_sum);
    case (r_mode)
      2'd1:    w_res = f_sat(SW'(w_max));
      2'd2:    w_res = (w_sum >= r_thresh) ? '1 : '0;
      default: w_res = f_sat(w_sum);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_dir   <= 2'd0;
    end else if (w_gen) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
      r_out_sof   <= w_sof;
      r_out_eof   <= w_eof;
      r_out_dir   <= w_dir;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sof   = r_out_sof;
  assign out_eof   = r_out_eof;
`ifdef MOR_GRAD_DIR_EN
  assign out_dir   = r_out_dir;
`else
  logic w_dir_unused;
  assign w_dir_unused = ^r_out_dir;
`endif

endmodule

// File: tb/tb_mor_gradient_stream.sv
// Directed/table-driven bench for mor_gradient_stream on an 8x6 frame,
// with OUT_W=10 and OUT_W=8 instances sharing one input stream.
module tb_mor_gradient_stream;
  localparam int PW = 8;
  localparam int IW = 8;
  localparam int IH = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic out_ready = 1'b1;
  logic [PW-1:0] in_pixel = '0;
  logic [1:0] mode = 2'd0;
  logic [PW+2:0] thresh = '0;
  logic in_ready_a, in_ready_b, ov_a, ov_b, sof_a, sof_b, eof_a, eof_b;
  logic [9:0] od_a;
  logic [7:0] od_b;
  logic [1:0] dir_a, dir_b;

  mor_gradient_stream #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH), .OUT_W(10)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_pixel(in_pixel), .in_sof(in_sof), .mode(mode), .thresh(thresh),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
    .out_sof(sof_a), .out_eof(eof_a)
`ifdef MOR_GRAD_DIR_EN
    , .out_dir(dir_a)
`endif
  );

  mor_gradient_stream #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH), .OUT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_pixel(in_pixel), .in_sof(in_sof), .mode(mode), .thresh(thresh),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
    .out_sof(sof_b), .out_eof(eof_b)
`ifdef MOR_GRAD_DIR_EN
    , .out_dir(dir_b)
`endif
  );

`ifndef MOR_GRAD_DIR_EN
  assign dir_a = 2'd0;
  assign dir_b = 2'd0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fv_cyc = -1;
  int acc_cyc = -2;
  bit rnd_rdy = 1'b0;
  int pix [IH][IW];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] da;
    logic [7:0] db;
    logic       sof;
    logic       eof;
    logic [1:0] dir;
  } res_t;
  res_t q[$];

  typedef struct {
    int pat;  // 0 flat, 1 vertical step, 2 random
    int md;
    int thr;
    int rnd;  // random in_valid gaps and out_ready
    int chg;  // change mode pin mid-frame
    int ea, oa, eb, ob, edir;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: handshake rule, stall stability, result capture
  bit stall_prev = 1'b0;
  logic [9:0] held_a;
  logic held_sof, held_eof;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", int'(in_ready_a), int'(!ov_a || out_ready));
      if (stall_prev) begin
        chk("stall_valid", int'(ov_a), 1);
        chk("stall_data", int'(od_a), int'(held_a));
        chk("stall_sof", int'(sof_a), int'(held_sof));
        chk("stall_eof", int'(eof_a), int'(held_eof));
      end
      stall_prev = ov_a && !out_ready;
      held_a = od_a;
      held_sof = sof_a;
      held_eof = eof_a;
      if (ov_a && fv_cyc < 0) fv_cyc = cyc;
      if (ov_a && out_ready) q.push_back('{od_a, od_b, sof_a, eof_a, dir_a});
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int dval(input int r, input int c, input int k);
    int z5;
    z5 = pix[r][c];
    case (k)
      0: return iabs(z5 - pix[r-1][c]) + iabs(pix[r+1][c] - z5);
      1: return iabs(z5 - pix[r][c-1]) + iabs(pix[r][c+1] - z5);
      2: return iabs(z5 - pix[r-1][c-1]) + iabs(pix[r+1][c+1] - z5);
      default: return iabs(z5 - pix[r-1][c+1]) + iabs(pix[r+1][c-1] - z5);
    endcase
  endfunction

  function automatic int model(input int r, input int c, input int md, input int thr, input int ow);
    int s, m, mx;
    s = 0;
    m = 0;
    mx = (1 << ow) - 1;
    for (int k = 0; k < 4; k++) begin
      s += dval(r, c, k);
      if (dval(r, c, k) > m) m = dval(r, c, k);
    end
    if (md == 1) return (m > mx) ? mx : m;
    if (md == 2) return (s >= thr) ? mx : 0;
    return (s > mx) ? mx : s;
  endfunction

  function automatic int model_dir(input int r, input int c);
    int best;
    best = 0;
    for (int k = 1; k < 4; k++)
      if (dval(r, c, k) > dval(r, c, best)) best = k;
    return best;
  endfunction

  task automatic fill(input int pat);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        pix[r][c] = (pat == 0) ? 50 : (pat == 1) ? ((c < 4) ? 10 : 110) : int'($urandom_range(0, 255));
  endtask

  // Called at posedge+1; returns at posedge+1 after the last accepting edge
  task automatic drive_frame(input int npix, input int gaps, input int chg);
    for (int i = 0; i < npix; i++) begin
      int tmo;
      if (gaps != 0) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_pixel = PW'(pix[i / IW][i % IW]);
      in_sof = (i == 0);
      if (chg != 0 && i == 20) mode = 2'd0;
      tmo = 0;
      forever begin
        @(negedge clk);
        if (in_ready_a) break;
        tmo++;
        if (tmo > 200) break;
        @(posedge clk);
        #1;
      end
      if (tmo > 200) begin
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_sof = 1'b0;
        return;
      end
      if (i == 2 * IW + 2) acc_cyc = cyc + 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!ov_a) break;
    end
    chk("drained", int'(ov_a), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int pat, input int md, input int thr,
                             input int ea, input int oa, input int eb, input int ob, input int edir);
    chk($sformatf("%s count", tag), q.size(), 24);
    for (int k = 0; k < 24 && k < q.size(); k++) begin
      int r, c, xa, xb, xd;
      r = 1 + k / 6;
      c = 1 + k % 6;
      if (pat == 2) begin
        xa = model(r, c, md, thr, 10);
        xb = model(r, c, md, thr, 8);
        xd = model_dir(r, c);
      end else if (pat == 1 && (c == 3 || c == 4)) begin
        xa = ea; xb = eb; xd = edir;
      end else begin
        xa = oa; xb = ob; xd = 0;
      end
      chk($sformatf("%s data10 r%0d c%0d", tag, r, c), int'(q[k].da), xa);
      chk($sformatf("%s data8 r%0d c%0d", tag, r, c), int'(q[k].db), xb);
      chk($sformatf("%s sof r%0d c%0d", tag, r, c), int'(q[k].sof), int'(k == 0));
      chk($sformatf("%s eof r%0d c%0d", tag, r, c), int'(q[k].eof), int'(k == 23));
`ifdef MOR_GRAD_DIR_EN
      chk($sformatf("%s dir r%0d c%0d", tag, r, c), int'(q[k].dir), xd);
`endif
    end
  endtask

  initial begin
    //          pat md thr rnd chg  ea    oa eb   ob edir
    tbl[0] = '{0, 0, 0,   0, 0,   0,    0, 0,   0, 0};
    tbl[1] = '{1, 0, 0,   0, 0,   300,  0, 255, 0, 1};
    tbl[2] = '{1, 1, 0,   0, 0,   100,  0, 100, 0, 1};
    tbl[3] = '{1, 2, 200, 0, 0,   1023, 0, 255, 0, 1};
    tbl[4] = '{1, 2, 200, 0, 1,   1023, 0, 255, 0, 1};
    tbl[5] = '{1, 3, 0,   0, 0,   300,  0, 255, 0, 1};
    tbl[6] = '{2, 0, 0,   1, 0,   0,    0, 0,   0, 0};
    tbl[7] = '{2, 1, 0,   1, 0,   0,    0, 0,   0, 0};
    tbl[8] = '{2, 2, 300, 1, 0,   0,    0, 0,   0, 0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", int'(ov_a), 0);
    chk("rst out_data", int'(od_a), 0);
    chk("rst out_sof", int'(sof_a), 0);
    chk("rst out_eof", int'(eof_a), 0);
    chk("rst in_ready", int'(in_ready_a), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      fill(tbl[i].pat);
      mode = 2'(tbl[i].md);
      thresh = 11'(tbl[i].thr);
      rnd_rdy = (tbl[i].rnd != 0);
      q.delete();
      fv_cyc = -1;
      acc_cyc = -2;
      drive_frame(IW * IH, tbl[i].rnd, tbl[i].chg);
      drain();
      rnd_rdy = 1'b0;
      @(posedge clk);
      #1;
      if (tbl[i].rnd == 0) chk($sformatf("vec%0d latency", i), fv_cyc, acc_cyc);
      check_frame($sformatf("vec%0d", i), tbl[i].pat, tbl[i].md, tbl[i].thr,
                  tbl[i].ea, tbl[i].oa, tbl[i].eb, tbl[i].ob, tbl[i].edir);
    end

    // Restart mid-frame with in_sof after a partial frame
    fill(2);
    mode = 2'd0;
    thresh = '0;
    q.delete();
    drive_frame(2 * IW + 2, 0, 0);
    repeat (3) @(negedge clk);
    chk("partial count", q.size(), 0);
    @(posedge clk);
    #1;
    fill(2);
    q.delete();
    drive_frame(IW * IH, 0, 0);
    drain();
    check_frame("resof", 2, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset between clock edges mid-frame
    fill(1);
    mode = 2'd0;
    q.delete();
    drive_frame(3 * IW + 4, 0, 0);
    chk("pre-reset valid", int'(ov_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", int'(ov_a), 0);
    chk("async rst out_data", int'(od_a), 0);
    chk("async rst out_sof", int'(sof_a), 0);
    chk("async rst in_ready", int'(in_ready_a), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    drive_frame(IW * IH, 0, 0);
    drain();
    check_frame("postrst", 1, 0, 0, 300, 0, 255, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mor_gradient_stream.md
Name: mor_gradient_stream

Overview:
- Streaming 3x3 morphological-gradient edge engine for the OV7670 pixel path.
- Accepts a raster pixel stream with a valid/ready handshake and builds the 3x3 window internally from two line buffers.
- Computes the four directional gradients and emits one result per interior pixel, in a runtime-selectable mode, with saturation to a parametrised output width.
- Sits between the camera capture/grayscale stage and the frame-buffer writer.

Parameters:
- PIX_W, 8, input pixel width in bits.
- IMG_W, 640, pixels per line (>=3).
- IMG_H, 480, lines per frame (>=3).
- OUT_W, 8, result width in bits (1..PIX_W+3).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_pixel  in  PIX_W  grayscale pixel, raster order.
- in_sof  in  1  marks the first pixel of a frame (qualified by in_valid&&in_ready).
- mode  in  2  0=sum, 1=max, 2=threshold, 3=reserved (acts as 0).
- thresh  in  PIX_W+3  threshold used by mode 2.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W  gradient result.
- out_sof  out  1  first interior result of the frame.
- out_eof  out  1  last interior result of the frame.

Behaviour:
- Reset: clk rising edge, rst_n asynchronous active-low.
  - Outputs on reset: out_valid=0, out_data=0, out_sof=0, out_eof=0.
  - Internal state on reset: column/row counters=0, latched mode=0, latched thresh=0.
  - Line-buffer contents are not reset.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register stage).
  - A pixel transfers when in_valid && in_ready.
  - out_data/out_sof/out_eof hold stable while out_valid && !out_ready.
- Counters:
  - col advances on each accepted pixel; at IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1) both wrap to 0.
  - An accepted in_sof forces that pixel to (0,0) and restarts counting, including mid-frame. Stale line data is harmless because of output gating.
- Mode/thresh are latched on an accepted in_sof and held for the whole frame.
- Window:
  - z1..z9 in raster order; z5 is the centre.
  - z7..z9 come from the current line, z4..z6 from line buffer 1, z1..z3 from line buffer 2, with shift registers for the column taps.
- Output gating: when the accepted pixel sits at row>=2 and col>=2, the result for centre (row-1, col-1) is registered.
  - out_valid rises the next cycle: latency is 1 cycle after the accepting edge.
  - Border pixels produce nothing, so (IMG_W-2)*(IMG_H-2) results are produced per frame.
- Arithmetic (unsigned, no overflow internally):
  - D1=|z5-z2|+|z8-z5|, D2=|z5-z4|+|z6-z5|, D3=|z5-z1|+|z9-z5|, D4=|z5-z3|+|z7-z5|. Each D is PIX_W+1 bits.
  - S = D1+D2+D3+D4 (PIX_W+3 bits). M = max(D1..D4).
- Mode results:
  - mode 0: out_data = min(S, 2^OUT_W-1).
  - mode 1: out_data = min(M, 2^OUT_W-1).
  - mode 2: out_data = all ones if S>=thresh, else 0.
- Flags:
  - out_sof=1 on the result for centre (1,1).
  - out_eof=1 on the result for centre (IMG_H-2, IMG_W-2).
- Output register: if out_valid && out_ready and no new result is generated in the same cycle, out_valid falls. A simultaneous pop and new result loads the new result and keeps out_valid=1.

Optional Feature:
- Macro: MOR_GRAD_DIR_EN.
- Defined:
  - Adds port out_dir, output, 2 bits: index (0..3 = D1..D4) of the largest directional gradient; ties resolve to the lowest index.
  - out_dir is registered alongside out_data and is 0 on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (IMG_W=8, IMG_H=6, PIX_W=8, OUT_W=10 unless stated):
- Flat frame, all pixels 50, mode 0, out_ready=1 -> exactly 24 results, all 0; out_sof on the first, out_eof on the 24th; first out_valid 1 cycle after pixel (2,2) is accepted.
- Vertical step (cols 0-3 = 10, cols 4-7 = 110), mode 0 -> centres at col 3 and col 4 give 300; all other results 0.
- Same step, mode 1 -> col 3/col 4 give 100. Same step with OUT_W=8, mode 0 -> 255 (saturated).
- Same step, mode 2, thresh=200 -> col 3/col 4 give 1023, others 0. Change mode mid-frame -> no effect until the next in_sof.
- Random out_ready at 50% and random in_valid gaps over 2 frames -> output sequence identical to a golden model; no result dropped or duplicated; out_data stable while stalled.
- Reset asserted asynchronously mid-frame (between clock edges) -> outputs clear immediately. In_sof asserted mid-frame without reset -> counting restarts and the next 24 results match a fresh frame. With MOR_GRAD_DIR_EN: step frame at col 3 -> out_dir=1 (D2, D3, D4 all equal 100; lowest index wins).
